spi_flash_sequencer: RTL

SPI_FLASH_SEQUENCER -- requirements
Module: spi_flash_sequencer

---
 rtl/spi_flash_sequencer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer
//   Turns a single flash operation request into the sequence of SPI flash
//   commands handed to a downstream command engine. Read ID and read are
//   one command each; sector erase and page program are preceded by WREN
//   and followed by RDSR polling of the WIP bit, with an idle gap between
//   polls and a bounded poll count.
//
//   Optional build macro: SPI_SEQ_WEL_CHECK_EN
//     When defined, one RDSR follows the WREN acknowledge. The operation
//     aborts with an error if WEL (status[1]) is not set.
//
// Parameters
//   POLL_LIMIT  maximum RDSR polls per erase/program before error
//   POLL_GAP    idle sys_clk cycles between consecutive RDSR polls
//
// Ports
//   sys_clk    system clock, rising edge
//   rst_n      asynchronous active-low reset
//   op_req     operation request, sampled only in IDLE
//   op_code    0 read ID, 1 read, 2 sector erase, 3 page program
//   op_addr    flash byte address
//   op_size    data byte count for read/program, 1..256
//   op_busy    high from the cycle after acceptance until back in IDLE
//   op_done    one-cycle completion pulse
//   op_err     one-cycle failure pulse, coincident with op_done
//   status     last captured flash status register
//   cmd        command code to the command engine
//   cmd_valid  command request
//   cmd_ack    one-cycle command completion from the engine
//   cmd_addr   address to the command engine
//   cmd_size   data byte count to the command engine
//   rd_data    received byte from the command engine
//   rd_valid   rd_data qualifier
module spi_flash_sequencer #(
  parameter logic [15:0] POLL_LIMIT = 16'd50000,
  parameter logic [7:0]  POLL_GAP   = 8'd100
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        op_req,
  input  logic [1:0]  op_code,
  input  logic [23:0] op_addr,
  input  logic [8:0]  op_size,
  output logic        op_busy,
  output logic        op_done,
  output logic        op_err,
  output logic [7:0]  status,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic [23:0] cmd_addr,
  output logic [8:0]  cmd_size,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LATCH    = 3'd1;
  localparam logic [2:0] ST_WREN     = 3'd2;
  localparam logic [2:0] ST_POLL     = 3'd3;
  localparam logic [2:0] ST_POLL_GAP = 3'd4;
  localparam logic [2:0] ST_MAIN     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;

  logic [2:0]  state;
  logic [1:0]  code_q;
  logic [23:0] addr_q;
  logic [8:0]  size_q;
  logic [15:0] poll_cnt;
  logic [7:0]  gap_cnt;
`ifdef SPI_SEQ_WEL_CHECK_EN
  logic        wel_phase;
`endif

  logic        ack;
  logic        is_cmd_state;
  logic        size_bad;
  logic [7:0]  st_now;
  logic [15:0] poll_next;
  logic [7:0]  nxt_cmd;
  logic [23:0] nxt_addr;
  logic [8:0]  nxt_size;

  always_comb begin
    ack          = cmd_valid & cmd_ack;
    is_cmd_state = (state == ST_WREN) || (state == ST_MAIN) || (state == ST_POLL);
    size_bad     = (size_q == '0) || (size_q > 9'd256);
    poll_next    = poll_cnt + 16'd1;
    // Status byte as it will be after this edge; lets the ack decision see
    // a status byte that arrives in the same cycle as cmd_ack.
    st_now = (rd_valid && cmd_valid && (state == ST_POLL)) ? rd_data : status;

    nxt_cmd  = CMD_PP;
    nxt_addr = addr_q;
    nxt_size = size_q;
    if (state == ST_WREN) begin
      nxt_cmd  = CMD_WREN;
      nxt_addr = '0;
      nxt_size = '0;
    end else if (state == ST_POLL) begin
      nxt_cmd  = CMD_RDSR;
      nxt_addr = '0;
      nxt_size = 9'd1;
    end else begin
      unique case (code_q)
        2'd0: begin
          nxt_cmd  = CMD_RDID;
          nxt_addr = '0;
          nxt_size = 9'd3;
        end
        2'd1:    nxt_cmd = CMD_READ;
        2'd2: begin
          nxt_cmd  = CMD_SE;
          nxt_size = '0;
        end
        default: nxt_cmd = CMD_PP;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      code_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
`ifdef SPI_SEQ_WEL_CHECK_EN
      wel_phase <= 1'b0;
`endif
      op_busy   <= 1'b0;
      op_done   <= 1'b0;
      op_err    <= 1'b0;
      status    <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_size  <= '0;
    end else begin
      op_done <= 1'b0;
      op_err  <= 1'b0;
      status  <= st_now;

      // Every command state issues its command one cycle after entry and
      // leaves on the acknowledge, so cmd_valid is low again on entry to
      // the next command state.
      if (is_cmd_state && !cmd_valid) begin
        cmd       <= nxt_cmd;
        cmd_addr  <= nxt_addr;
        cmd_size  <= nxt_size;
        cmd_valid <= 1'b1;
      end
      if (ack) cmd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (op_req) begin
            code_q  <= op_code;
            addr_q  <= op_addr;
            size_q  <= op_size;
            op_busy <= 1'b1;
            state   <= ST_LATCH;
          end
        end

        ST_LATCH: begin
          poll_cnt <= '0;
          gap_cnt  <= '0;
          if (size_bad) begin
            op_done <= 1'b1;
            op_err  <= 1'b1;
            state   <= ST_ERR;
          end else if (code_q[1]) begin
            state <= ST_WREN;
          end else begin
            state <= ST_MAIN;
          end
        end

        ST_WREN: begin
          if (ack) begin
`ifdef SPI_SEQ_WEL_CHECK_EN
            wel_phase <= 1'b1;
            state     <= ST_POLL;
`else
            state     <= ST_MAIN;
`endif
          end
        end

        ST_MAIN: begin
          if (ack) begin
            if (code_q[1]) begin
              state <= ST_POLL;
            end else begin
              op_done <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end

        ST_POLL: begin
          if (ack) begin
`ifdef SPI_SEQ_WEL_CHECK_EN
            if (wel_phase) begin
              wel_phase <= 1'b0;
              if (!st_now[1]) begin
                op_done <= 1'b1;
                op_err  <= 1'b1;
                state   <= ST_ERR;
              end else begin
                state <= ST_MAIN;
              end
            end else
`endif
            begin
              poll_cnt <= poll_next;
              if (!st_now[0]) begin
                op_done <= 1'b1;
                state   <= ST_DONE;
              end else if (poll_next >= POLL_LIMIT) begin
                op_done <= 1'b1;
                op_err  <= 1'b1;
                state   <= ST_ERR;
              end else if (POLL_GAP == 8'd0) begin
                state <= ST_POLL;
              end else begin
                gap_cnt <= '0;
                state   <= ST_POLL_GAP;
              end
            end
          end
        end

        ST_POLL_GAP: begin
          if (gap_cnt == POLL_GAP - 8'd1) begin
            gap_cnt <= '0;
            state   <= ST_POLL;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        ST_DONE, ST_ERR: begin
          op_busy <= 1'b0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
